// File: rtl/trace_checker_pkg.sv
// ============================================================================
// trace_checker_pkg : shared types and constants for the writeback trace checker
// Revision: 1.0
// ============================================================================
`default_nettype none

package trace_checker_pkg;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_PC    = 3'd1;
    localparam logic [2:0] ERR_WNUM  = 3'd2;
    localparam logic [2:0] ERR_WDATA = 3'd3;
    localparam logic [2:0] ERR_OVF   = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ENTRY_W = 73;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [3:0]  we;
    } entry_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) m[8*b +: 8] = 8'hff;
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_checker_if.sv
// ============================================================================
// trace_checker_if : CPU writeback trace port plus golden-stream handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface trace_checker_if;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        ref_valid;
    logic        ref_ready;
    logic [31:0] ref_pc;
    logic [4:0]  ref_wnum;
    logic [31:0] ref_wdata;

    modport master (
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output ref_valid, ref_pc, ref_wnum, ref_wdata,
        input  ref_ready
    );

    modport slave (
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input  ref_valid, ref_pc, ref_wnum, ref_wdata,
        output ref_ready
    );
endinterface

`default_nettype wire

// File: rtl/trace_checker_fifo.sv
// ============================================================================
// trace_fifo : capture FIFO of retired register writes, wrap-bit pointers
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_fifo
    import trace_checker_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       resetn,
    input  wire logic                       clr,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire entry_t                     din,
    output      entry_t                     dout,
    output      logic                       full,
    output      logic                       empty,
    output      logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic            w_wr;
    logic            w_rd;

    assign level = wptr_q - rptr_q;
    assign full  = (level == FULL_LVL);
    assign empty = (wptr_q == rptr_q);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    // A write into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_wr = push && (!full || pop);
    assign w_rd = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_wr) begin
                mem_q[wptr_q[AW-1:0]] <= din;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (w_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trace_checker.sv
// ============================================================================
// trace_checker : compares retired CPU register writes against a golden trace
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int          DEPTH  = 8,
    parameter logic [31:0] END_PC = 32'h1c000100
) (
    input  wire logic                   clk,
    input  wire logic                   resetn,
    input  wire logic                   enable,
    input  wire logic                   clr,
    trace_checker_if.slave              tr,
    output      logic                   pass,
    output      logic                   fail,
    output      logic [2:0]             err_code,
    output      logic [31:0]            err_pc,
    output      logic [31:0]            err_exp,
    output      logic [31:0]            err_got,
    output      logic [31:0]            retire_cnt,
    output      logic [$clog2(DEPTH):0] fifo_level
);

    state_t      state_q;
    logic        pass_q;
    logic        fail_q;
    logic [2:0]  err_code_q;
    logic [31:0] err_pc_q;
    logic [31:0] err_exp_q;
    logic [31:0] err_got_q;
    logic [31:0] retire_cnt_q;

    entry_t      w_din;
    entry_t      w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_run;
    logic        w_push;
    logic        w_pop;
    logic        w_ovf;
    logic        w_end;
    logic [31:0] w_mask;
    logic [2:0]  w_cmp_code;

    assign w_run  = (state_q == RUN);
    assign w_push = w_run && (tr.debug_wb_rf_we != 4'd0) && (tr.debug_wb_rf_wnum != 5'd0);
    assign w_pop  = w_run && !w_empty && tr.ref_valid;
    assign w_ovf  = w_push && w_full && !w_pop;
    assign w_end  = (tr.debug_wb_pc == END_PC) && w_empty && !w_push;

    assign tr.ref_ready = w_pop;

    assign w_din = '{pc:    tr.debug_wb_pc,
                     wnum:  tr.debug_wb_rf_wnum,
                     wdata: tr.debug_wb_rf_wdata,
                     we:    tr.debug_wb_rf_we};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_din),
        .dout   (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .level  (fifo_level)
    );

    assign w_mask = byte_mask(w_head.we);

    always_comb begin
        w_cmp_code = ERR_NONE;
        if (w_head.pc != tr.ref_pc)
            w_cmp_code = ERR_PC;
        else if (w_head.wnum != tr.ref_wnum)
            w_cmp_code = ERR_WNUM;
        else if ((w_head.wdata & w_mask) != (tr.ref_wdata & w_mask))
            w_cmp_code = ERR_WDATA;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_pc_q     <= '0;
            err_exp_q    <= '0;
            err_got_q    <= '0;
            retire_cnt_q <= '0;
        end else if (clr) begin
            state_q      <= IDLE;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_pc_q     <= '0;
            err_exp_q    <= '0;
            err_got_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (enable) state_q <= RUN;
                RUN: begin
                    // A compare error and an overflow never coincide: overflow implies no pop.
                    if (w_pop && (w_cmp_code != ERR_NONE)) begin
                        state_q    <= ERROR;
                        fail_q     <= 1'b1;
                        err_code_q <= w_cmp_code;
                        err_pc_q   <= w_head.pc;
                        err_exp_q  <= tr.ref_wdata & w_mask;
                        err_got_q  <= w_head.wdata & w_mask;
                    end else if (w_ovf) begin
                        state_q    <= ERROR;
                        fail_q     <= 1'b1;
                        err_code_q <= ERR_OVF;
                        err_pc_q   <= tr.debug_wb_pc;
                        err_exp_q  <= '0;
                        err_got_q  <= tr.debug_wb_rf_wdata;
                    end else begin
                        if (w_pop && (retire_cnt_q != 32'hffff_ffff))
                            retire_cnt_q <= retire_cnt_q + 32'd1;
                        if (w_end) begin
                            state_q <= DONE;
                            pass_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass       = pass_q;
    assign fail       = fail_q;
    assign err_code   = err_code_q;
    assign err_pc     = err_pc_q;
    assign err_exp    = err_exp_q;
    assign err_got    = err_got_q;
    assign retire_cnt = retire_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_checker.sv
// ============================================================================
// tb_trace_checker : directed plus randomized bench against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trace_checker;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] END_PC = 32'h1c000100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        clr = 1'b0;
    logic        pass, fail;
    logic [2:0]  err_code;
    logic [31:0] err_pc, err_exp, err_got, retire_cnt;
    logic [3:0]  fifo_level;

    trace_checker_if tif();

    trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .clr        (clr),
        .tr         (tif),
        .pass       (pass),
        .fail       (fail),
        .err_code   (err_code),
        .err_pc     (err_pc),
        .err_exp    (err_exp),
        .err_got    (err_got),
        .retire_cnt (retire_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [3:0]  we;
    } ment_t;

    // Reference model: 0 idle, 1 running, 2 failed, 3 passed
    int          m_st;
    ment_t       m_q[$];
    logic [31:0] m_cnt, m_epc, m_exp, m_got;
    logic [2:0]  m_code;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [3:0] we);
        logic [31:0] m = 0;
        for (int b = 0; b < 4; b++) if (we[b]) m = m | (32'hff << (8 * b));
        return m;
    endfunction

    task automatic m_reset();
        m_st = 0; m_q.delete();
        m_cnt = 0; m_epc = 0; m_exp = 0; m_got = 0; m_code = 0;
    endtask

    task automatic check_all();
        bit exp_ready;
        exp_ready = (m_st == 1) && (m_q.size() > 0) && tif.ref_valid;
        chk_val("ref_ready",  tif.ref_ready, exp_ready);
        chk_val("pass",       pass, m_st == 3);
        chk_val("fail",       fail, m_st == 2);
        chk_val("err_code",   err_code, m_code);
        chk_val("err_pc",     err_pc, m_epc);
        chk_val("err_exp",    err_exp, m_exp);
        chk_val("err_got",    err_got, m_got);
        chk_val("retire_cnt", retire_cnt, m_cnt);
        chk_val("fifo_level", fifo_level, m_q.size());
    endtask

    task automatic m_step();
        int    sz;
        bit    push, pop, err;
        ment_t e;
        logic [31:0] mk;
        logic [2:0]  code;
        if (clr) begin
            m_reset();
        end else if (m_st == 0) begin
            if (enable) m_st = 1;
        end else if (m_st == 1) begin
            sz   = m_q.size();
            push = (tif.debug_wb_rf_we != 0) && (tif.debug_wb_rf_wnum != 0);
            pop  = (sz > 0) && tif.ref_valid;
            err  = 0;
            if (pop) begin
                e  = m_q.pop_front();
                mk = mask_of(e.we);
                code = 0;
                if (e.pc != tif.ref_pc) code = 1;
                else if (e.wnum != tif.ref_wnum) code = 2;
                else if ((e.wdata & mk) != (tif.ref_wdata & mk)) code = 3;
                if (code != 0) begin
                    err = 1; m_st = 2; m_code = code;
                    m_epc = e.pc; m_exp = tif.ref_wdata & mk; m_got = e.wdata & mk;
                end else if (m_cnt != 32'hffff_ffff) begin
                    m_cnt++;
                end
            end
            if (push) begin
                if (sz == DEPTH && !pop) begin
                    if (!err) begin
                        err = 1; m_st = 2; m_code = 4;
                        m_epc = tif.debug_wb_pc; m_exp = 0; m_got = tif.debug_wb_rf_wdata;
                    end
                end else begin
                    m_q.push_back('{tif.debug_wb_pc, tif.debug_wb_rf_wnum,
                                    tif.debug_wb_rf_wdata, tif.debug_wb_rf_we});
                end
            end
            if (!err && tif.debug_wb_pc == END_PC && sz == 0 && !push) m_st = 3;
        end
    endtask

    // Inputs are held from just after one rising edge to just after the next.
    task automatic cycle();
        @(negedge clk);
        check_all();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic [31:0] pc, input logic [4:0] wn,
                       input logic [31:0] wd, input logic [3:0] we);
        tif.debug_wb_pc = pc; tif.debug_wb_rf_wnum = wn;
        tif.debug_wb_rf_wdata = wd; tif.debug_wb_rf_we = we;
    endtask

    task automatic gold(input logic v, input logic [31:0] pc, input logic [4:0] wn,
                        input logic [31:0] wd);
        tif.ref_valid = v; tif.ref_pc = pc; tif.ref_wnum = wn; tif.ref_wdata = wd;
    endtask

    task automatic quiet();
        cpu(32'h1c000050, 5'd0, 32'd0, 4'd0);
        gold(1'b0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic restart();
        quiet(); clr = 1; cycle(); clr = 0; enable = 1; cycle();
    endtask

    initial begin
        logic [31:0] gpc;
        m_reset();
        quiet();
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_fail", fail, 0);
        chk_val("rst_level", fifo_level, 0);
        resetn = 1;

        // Matching stream ending at END_PC
        enable = 1; cycle();
        cpu(32'h1c000000, 5'd4, 32'h12345678, 4'hf); cycle();
        cpu(32'h1c000004, 5'd5, 32'h00000000, 4'hf); cycle();
        quiet(); gold(1, 32'h1c000000, 5'd4, 32'h12345678); cycle();
        gold(1, 32'h1c000004, 5'd5, 32'h00000000); cycle();
        quiet(); tif.debug_wb_pc = END_PC; cycle();
        quiet(); cycle();
        chk_val("t1_retire", retire_cnt, 2);
        chk_val("t1_pass", pass, 1);
        chk_val("t1_fail", fail, 0);
        chk_val("t1_code", err_code, 0);

        // Data mismatch
        restart();
        cpu(32'h1c000008, 5'd6, 32'h11, 4'hf); cycle();
        quiet(); gold(1, 32'h1c000008, 5'd6, 32'h10); cycle();
        quiet(); cycle();
        chk_val("t2_fail", fail, 1);
        chk_val("t2_code", err_code, 3);
        chk_val("t2_pc", err_pc, 32'h1c000008);
        chk_val("t2_exp", err_exp, 32'h10);
        chk_val("t2_got", err_got, 32'h11);
        chk_val("t2_retire", retire_cnt, 0);

        // Byte-masked compare
        restart();
        cpu(32'h1c00000c, 5'd7, 32'hAAAAAA55, 4'b0001); cycle();
        quiet(); gold(1, 32'h1c00000c, 5'd7, 32'h00000055); cycle();
        quiet(); cycle();
        chk_val("t3_retire", retire_cnt, 1);
        chk_val("t3_fail", fail, 0);

        // Overflow on the ninth push with no pop
        restart();
        for (int i = 0; i < 8; i++) begin
            cpu(32'h1c000200 + 4 * i, 5'(i + 1), 32'(i), 4'hf); cycle();
        end
        chk_val("t4_level8", fifo_level, 8);
        cpu(32'h1c000220, 5'd9, 32'hdeadbeef, 4'hf); cycle();
        quiet(); cycle();
        chk_val("t4_code", err_code, 4);
        chk_val("t4_pc", err_pc, 32'h1c000220);
        chk_val("t4_got", err_got, 32'hdeadbeef);
        chk_val("t4_exp", err_exp, 0);

        // Push and pop together while full is legal
        restart();
        for (int i = 0; i < 8; i++) begin
            cpu(32'h1c000200 + 4 * i, 5'(i + 1), 32'(i), 4'hf); cycle();
        end
        cpu(32'h1c000220, 5'd9, 32'hdeadbeef, 4'hf);
        gold(1, 32'h1c000200, 5'd1, 32'd0); cycle();
        quiet(); cycle();
        chk_val("t4b_fail", fail, 0);
        chk_val("t4b_level", fifo_level, 8);
        chk_val("t4b_retire", retire_cnt, 1);

        // Filtering and compare priority
        restart();
        cpu(32'h1c000300, 5'd0, 32'h1, 4'hf); cycle();
        cpu(32'h1c000304, 5'd3, 32'h1, 4'h0); cycle();
        chk_val("t5_level0", fifo_level, 0);
        cpu(32'h1c000308, 5'd9, 32'h1, 4'hf); cycle();
        quiet(); gold(1, 32'h1c00030c, 5'd9, 32'h2); cycle();
        quiet(); cycle();
        chk_val("t5_code", err_code, 1);

        // Clear and asynchronous reset mid-run
        restart();
        for (int i = 0; i < 3; i++) begin
            cpu(32'h1c000400 + 4 * i, 5'(i + 1), 32'(i), 4'hf); cycle();
        end
        quiet(); clr = 1; cycle(); clr = 0; enable = 0;
        gold(1, 32'h1c000400, 5'd1, 32'd0); #1;
        chk_val("t6_clr_level", fifo_level, 0);
        chk_val("t6_clr_ready", tif.ref_ready, 0);
        cycle();
        chk_val("t6_idle_ready", tif.ref_ready, 0);
        enable = 1; quiet(); cycle();
        for (int i = 0; i < 3; i++) begin
            cpu(32'h1c000400 + 4 * i, 5'(i + 1), 32'(i), 4'hf); cycle();
        end
        quiet(); gold(1, 32'h1c000400, 5'd1, 32'd0); cycle();
        #2 resetn = 0; #1;
        m_reset();
        chk_val("t6_rst_ready", tif.ref_ready, 0);
        chk_val("t6_rst_level", fifo_level, 0);
        chk_val("t6_rst_retire", retire_cnt, 0);
        chk_val("t6_rst_flags", {pass, fail, err_code}, 0);
        chk_val("t6_rst_err", {err_pc, err_exp}, 0);
        chk_val("t6_rst_got", err_got, 0);
        @(posedge clk); #1;
        resetn = 1;

        // Randomized streams; golden side mirrors the model's queue head with rare corruption
        gpc = 32'h1c001000;
        for (int run = 0; run < 10; run++) begin
            restart();
            for (int c = 0; c < 200 && m_st == 1; c++) begin
                if ($urandom_range(9) < 6) begin
                    cpu(gpc, 5'($urandom_range(31)),
                        $urandom, ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15, 1)));
                    gpc += 4;
                end else begin
                    cpu(($urandom_range(30) == 0) ? END_PC : gpc, 5'($urandom_range(31)),
                        $urandom, 4'd0);
                end
                if (m_q.size() > 0) begin
                    gold($urandom_range(1) == 1, m_q[0].pc, m_q[0].wnum, m_q[0].wdata);
                    if ($urandom_range(29) == 0) begin
                        case ($urandom_range(2))
                            0: tif.ref_pc    ^= 32'h4 << $urandom_range(8);
                            1: tif.ref_wnum  ^= 5'(1 << $urandom_range(4));
                            default: tif.ref_wdata ^= 32'h1 << $urandom_range(31);
                        endcase
                    end
                end else begin
                    gold($urandom_range(1) == 1, $urandom, 5'($urandom_range(31)), $urandom);
                end
                cycle();
            end
            quiet(); cycle(); cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Receiver for the CPU's writeback trace port (debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata).
- Captures every retired register write into a small FIFO and compares it, in order, against a golden trace stream supplied over a valid/ready interface.
- Reports pass/fail, the first mismatch and a retire count.
- Sits beside mycpu_top in the SoC/FPGA wrapper. The CPU cannot be back-pressured, so the FIFO absorbs golden-stream stalls.

Parameters:
- DEPTH, 8, capture FIFO entries; power of two, ≥2.
- END_PC, 32'h1c000100, PC that marks end of test.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- enable  in  1  level; start checking when high in IDLE.
- clr  in  1  synchronous clear: flush the FIFO, zero counters and error registers, go to IDLE.
- debug_wb_pc  in  32  PC of the writing-back instruction.
- debug_wb_rf_we  in  4  byte write enables.
- debug_wb_rf_wnum  in  5  destination register.
- debug_wb_rf_wdata  in  32  write data.
- ref_valid  in  1  golden entry valid.
- ref_ready  out  1  golden entry consumed this cycle.
- ref_pc  in  32  expected PC.
- ref_wnum  in  5  expected register.
- ref_wdata  in  32  expected data.
- pass  out  1  sticky; end reached with no error.
- fail  out  1  sticky; error detected.
- err_code  out  3  0 none, 1 pc, 2 wnum, 3 wdata, 4 overflow.
- err_pc  out  32  captured PC at the first error.
- err_exp  out  32  expected wdata at the first error.
- err_got  out  32  masked got wdata at the first error.
- retire_cnt  out  32  number of successful compares.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (resetn=0, async): state=IDLE, FIFO empty. All outputs 0, including ref_ready, pass, fail, err_*, retire_cnt, fifo_level. A reset in mid-operation discards all state immediately.
- clr=1 (synchronous): same effect as reset. clr has priority over all other events in that cycle.
- States:
  - IDLE: nothing captured. Go to RUN when enable=1.
  - RUN: capture and compare.
  - ERROR: terminal; fail=1.
  - DONE: terminal; pass=1.
  - Leave ERROR or DONE only via clr or reset.
- Capture (RUN only): push {pc, wnum, wdata, we} when debug_wb_rf_we!=0 && debug_wb_rf_wnum!=0. Events outside RUN are ignored.
- Compare (RUN only): when FIFO non-empty && ref_valid:
  - ref_ready=1 for one cycle; pop both sides in the same cycle.
  - mask = byte-expand(we). Check in priority order: pc != ref_pc → code 1; wnum != ref_wnum → code 2; (wdata&mask) != (ref_wdata&mask) → code 3.
  - On mismatch, on the next edge: state=ERROR; latch err_code, err_pc=captured pc, err_exp=ref_wdata&mask, err_got=wdata&mask. retire_cnt is not incremented.
  - On match: retire_cnt+1, saturating at 32'hffffffff.
- ref_ready is combinational: (state==RUN) && FIFO non-empty && ref_valid.
- Overflow: if a push occurs while the FIFO is full and no pop happens that cycle → ERROR, err_code=4, err_pc=debug_wb_pc, err_exp=0, err_got=debug_wb_rf_wdata. Push and pop in the same cycle while full is legal and is not an overflow.
- Same-cycle push and pop on an empty FIFO: the new entry is not bypassed; it is compared on a later cycle.
- End of test: in RUN, when debug_wb_pc==END_PC and the FIFO is empty with no push this cycle → DONE on the next edge. If a compare error and the end condition occur in the same cycle, ERROR wins.
- FIFO pointers have log2(DEPTH)+1 bits and wrap naturally. fifo_level = wptr - rptr.

Decomposition:
- Shared package: err_code constants (ERR_NONE..ERR_OVF), state encoding (IDLE/RUN/ERROR/DONE), and the trace entry struct/width (73 bits).
- One sub-module: trace_fifo. Synchronous-write register array with async active-low reset; ports push, pop, din, dout, full, empty, level.
- The checker FSM, compare logic and error registers stay in trace_checker.

Test Plan:
- Match stream: enable=1; CPU writes (1c000000,r4,32'h12345678,we=f) and (1c000004,r5,32'h0,we=f); golden stream identical; then pc=1c000100 → retire_cnt=2, pass=1, fail=0, err_code=0.
- Data mismatch: got wdata 32'h00000011, expected 32'h00000010 at pc 1c000008, r6 → fail=1, err_code=3, err_pc=1c000008, err_exp=10, err_got=11, retire_cnt unchanged.
- Byte mask: we=4'b0001, got 32'hAAAA_AA55, expected 32'h0000_0055 → match, retire_cnt+1.
- Overflow: DEPTH=8, ref_valid=0, 9 consecutive writes → fifo_level reaches 8, then err_code=4 on the 9th push. A variant asserting ref_valid in that cycle produces no error.
- Filtering and ordering: writes to r0 and we=0 are not captured (fifo_level stays 0); a pc mismatch plus wdata mismatch on the same entry reports err_code=1.
- Reset/clear mid-run: after 3 pushes, pulse clr → fifo_level=0, state IDLE, ref_ready=0. Assert resetn low asynchronously between clock edges → all outputs 0 immediately.
